// File: rtl/multi_frequency_counter_pkg.sv
// Purpose: shared register map, bit positions, FSM states and helpers for the frequency meter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package multi_frequency_counter_pkg;

    // Register word offsets on the control bus
    localparam logic [11:0] ADDR_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_STATUS = 12'h004;
    localparam logic [11:0] ADDR_GATE   = 12'h008;
    localparam logic [11:0] ADDR_INFO   = 12'h00C;
    localparam logic [11:0] ADDR_SEQ    = 12'h010;
    localparam logic [11:0] ADDR_OVF    = 12'h014;
    localparam logic [11:0] RESULT_BASE = 12'h100;

    // CTRL bits: enable/mode are stored, start/clear are one-shot pulses
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_CLEAR  = 3;

    // STATUS bits
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_OVF_LSB = 16;

    // Gate FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;

    // Every access completes with OKAY
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Merge a write into an existing register honouring byte enables
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_frequency_counter_if.sv
// Purpose: AXI4-Lite control bus bundle between software master and the meter slave.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs of each channel.
interface multi_frequency_counter_if;
    logic        arvalid;
    logic        arready;
    logic [11:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [11:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/freq_counter_channel.sv
// Purpose: one sensor channel: synchroniser, rising-edge detect, saturating counter, sticky overflow.
// Latency: edge pulse SYNC_STAGES+1 cycles after the input transition; cnt_next_o is combinational.
// Backpressure: none; every synchronised edge is consumed the cycle it appears.
module freq_counter_channel #(
    parameter int CNT_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sen_i,
    input  logic                 gate_i,
    input  logic                 zero_i,
    input  logic                 clr_ovf_i,
    output logic [CNT_WIDTH-1:0] cnt_next_o,
    output logic                 ovf_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   edge_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   sat;
    logic                   hit;

    // Bring the asynchronous sensor into the clock domain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sen_i};
        end
    end

    // Registered rising-edge pulse on the synchronised signal
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            last_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

    assign sat = &cnt_q;
    assign hit = gate_i && edge_q;

    // The value including this cycle's edge, so a terminal-cycle edge lands in the result
    assign cnt_next_o = (hit && !sat) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    // Counter next state and sticky overflow; a new overflow beats a clear
    always_comb begin
        cnt_d = zero_i ? '0 : cnt_next_o;
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (hit && sat) begin
            ovf_d = 1'b1;
        end
    end

    // Counter and overflow state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: rtl/multi_frequency_counter.sv
// Purpose: multi-channel frequency meter with AXI4-Lite register access and gate-window FSM.
// Latency: read data one cycle after AR accept; write response one cycle after AW/W accept.
// Backpressure: one outstanding read and one outstanding write; arready/awready drop until R/B drain.
module multi_frequency_counter
    import multi_frequency_counter_pkg::*;
#(
    parameter int ACLK_FREQUENCY = 200000000,
    parameter int NUM_CHANNELS   = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_CHANNELS-1:0] sen_in,
    output logic                    irq,
    multi_frequency_counter_if.slave ctrl
);

    logic                 enable_q;
    logic                 mode_q;
    logic                 start_q;
    logic                 clear_q;
    logic [31:0]          gate_cycles_q;
    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic [31:0]          timer_q;
    logic [31:0]          timer_d;
    logic [31:0]          seq_q;
    logic [31:0]          seq_d;
    logic                 done_q;
    logic                 done_d;
    logic                 latch;
    logic                 zero_cnt;
    logic                 counting;
    logic [31:0]          result_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_w;
    logic [31:0]          ovf_ext;
    logic [31:0]          status_w;
    logic [31:0]          rd_val;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 bvalid_q;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 wr_ctrl;
    logic                 wr_gate;
    logic [31:0]          gate_merged;
    logic [31:0]          gate_wr_val;

    // ---------------- channels ----------------
    assign counting = (state_q == ST_GATE);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        freq_counter_channel #(
            .CNT_WIDTH  (CNT_WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk_i     (aclk),
            .rst_i     (areset),
            .sen_i     (sen_in[g]),
            .gate_i    (counting),
            .zero_i    (zero_cnt),
            .clr_ovf_i (clear_q),
            .cnt_next_o(cnt_next[g]),
            .ovf_o     (ovf_w[g])
        );
    end

    assign ovf_ext = 32'(ovf_w);
    assign irq     = done_q;

    // ---------------- write side ----------------
    assign wr_fire      = ctrl.awvalid && ctrl.wvalid && !bvalid_q;
    assign ctrl.awready = wr_fire;
    assign ctrl.wready  = wr_fire;
    assign ctrl.bvalid  = bvalid_q;
    assign ctrl.bresp   = RESP_OKAY;
    assign wr_ctrl      = wr_fire && (ctrl.awaddr == ADDR_CTRL);
    assign wr_gate      = wr_fire && (ctrl.awaddr == ADDR_GATE);
    assign gate_merged  = apply_wstrb(gate_cycles_q, ctrl.wdata, ctrl.wstrb);
    // A zero-length window would never terminate, so it is stored as one cycle
    assign gate_wr_val  = (gate_merged == 32'd0) ? 32'd1 : gate_merged;

    // Control registers; start/clear are delayed a cycle so they see the updated enable/mode
    always_ff @(posedge aclk) begin
        if (areset) begin
            enable_q      <= 1'b0;
            mode_q        <= 1'b0;
            start_q       <= 1'b0;
            clear_q       <= 1'b0;
            gate_cycles_q <= 32'(ACLK_FREQUENCY);
        end else begin
            start_q <= wr_ctrl && ctrl.wstrb[0] && ctrl.wdata[CTRL_START];
            clear_q <= wr_ctrl && ctrl.wstrb[0] && ctrl.wdata[CTRL_CLEAR];
            if (wr_ctrl && ctrl.wstrb[0]) begin
                enable_q <= ctrl.wdata[CTRL_ENABLE];
                mode_q   <= ctrl.wdata[CTRL_MODE];
            end
            if (wr_gate) begin
                gate_cycles_q <= gate_wr_val;
            end
        end
    end

    // Write response holds until the master takes it
    always_ff @(posedge aclk) begin
        if (areset) begin
            bvalid_q <= 1'b0;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
        end else if (ctrl.bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // ---------------- read side ----------------
    assign rd_fire      = ctrl.arvalid && !rvalid_q;
    assign ctrl.arready = !rvalid_q;
    assign ctrl.rvalid  = rvalid_q;
    assign ctrl.rdata   = rdata_q;
    assign ctrl.rresp   = RESP_OKAY;

    // STATUS word assembly
    always_comb begin
        status_w                      = '0;
        status_w[STATUS_BUSY]         = counting;
        status_w[STATUS_DONE]         = done_q;
        status_w[31:STATUS_OVF_LSB]   = ovf_ext[15:0];
    end

    // Read address decode; anything unmapped returns zero
    always_comb begin
        rd_val = '0;
        case (ctrl.araddr)
            ADDR_CTRL: begin
                rd_val[CTRL_ENABLE] = enable_q;
                rd_val[CTRL_MODE]   = mode_q;
            end
            ADDR_STATUS: rd_val = status_w;
            ADDR_GATE:   rd_val = gate_cycles_q;
            ADDR_INFO:   rd_val = {16'h0000, 8'(CNT_WIDTH), 8'(NUM_CHANNELS)};
            ADDR_SEQ:    rd_val = seq_q;
            ADDR_OVF:    rd_val = ovf_ext;
            default: begin
                if (ctrl.araddr[11:7] == RESULT_BASE[11:7] && ctrl.araddr[1:0] == 2'b00) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (ctrl.araddr[6:2] == 5'(i)) begin
                            rd_val = result_q[i];
                        end
                    end
                end
            end
        endcase
    end

    // Read data register, stable until rready
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
        end else if (rvalid_q && ctrl.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- gate FSM ----------------
    // Window sequencing: start, countdown, terminal latch/reload, abort on enable loss
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        seq_d    = seq_q;
        done_d   = done_q;
        latch    = 1'b0;
        zero_cnt = 1'b0;
        if (clear_q) begin
            done_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable_q && (!mode_q || start_q)) begin
                    state_d  = ST_GATE;
                    timer_d  = gate_cycles_q - 32'd1;
                    zero_cnt = 1'b1;
                end
            end
            ST_GATE: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (timer_q == 32'd0) begin
                    latch    = 1'b1;
                    seq_d    = seq_q + 32'd1;
                    done_d   = 1'b1;
                    timer_d  = gate_cycles_q - 32'd1;
                    zero_cnt = 1'b1;
                    if (mode_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, timer, sequence and done state
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            seq_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            seq_q   <= seq_d;
            done_q  <= done_d;
        end
    end

    // Result registers capture the running counts on the terminal cycle
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                result_q[i] <= '0;
            end
        end else if (latch) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                result_q[i] <= 32'(cnt_next[i]);
            end
        end
    end

endmodule

// File: tb/tb_multi_frequency_counter.sv
// Purpose: directed self-checking bench for the frequency meter (32-bit and 8-bit counter builds).
// Latency: not applicable.
// Backpressure: bench master holds rready low in one scenario to exercise read stalls.
module tb_multi_frequency_counter;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] sen;
    logic [3:0] sen8;
    logic       irq;
    logic       irq8;
    int         checks   = 0;
    int         failures = 0;
    int         tick     = 0;
    int         cyc;

    // Bench-side master signals, steered to one of the two DUTs by sel
    logic        sel;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [11:0] m_araddr, m_awaddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    multi_frequency_counter_if ifc ();
    multi_frequency_counter_if ifc8 ();

    assign ifc.arvalid  = m_arvalid & ~sel;
    assign ifc8.arvalid = m_arvalid & sel;
    assign ifc.araddr   = m_araddr;
    assign ifc8.araddr  = m_araddr;
    assign ifc.rready   = m_rready & ~sel;
    assign ifc8.rready  = m_rready & sel;
    assign ifc.awvalid  = m_awvalid & ~sel;
    assign ifc8.awvalid = m_awvalid & sel;
    assign ifc.awaddr   = m_awaddr;
    assign ifc8.awaddr  = m_awaddr;
    assign ifc.wvalid   = m_wvalid & ~sel;
    assign ifc8.wvalid  = m_wvalid & sel;
    assign ifc.wdata    = m_wdata;
    assign ifc8.wdata   = m_wdata;
    assign ifc.wstrb    = m_wstrb;
    assign ifc8.wstrb   = m_wstrb;
    assign ifc.bready   = m_bready & ~sel;
    assign ifc8.bready  = m_bready & sel;

    wire        s_arready = sel ? ifc8.arready : ifc.arready;
    wire        s_rvalid  = sel ? ifc8.rvalid  : ifc.rvalid;
    wire [31:0] s_rdata   = sel ? ifc8.rdata   : ifc.rdata;
    wire [1:0]  s_rresp   = sel ? ifc8.rresp   : ifc.rresp;
    wire        s_awready = sel ? ifc8.awready : ifc.awready;
    wire        s_bvalid  = sel ? ifc8.bvalid  : ifc.bvalid;
    wire [1:0]  s_bresp   = sel ? ifc8.bresp   : ifc.bresp;
    wire        s_irq     = sel ? irq8 : irq;

    multi_frequency_counter #(
        .ACLK_FREQUENCY(200000000), .NUM_CHANNELS(4), .CNT_WIDTH(32), .SYNC_STAGES(2)
    ) dut (
        .aclk(clk), .areset(areset), .sen_in(sen), .irq(irq), .ctrl(ifc.slave)
    );

    multi_frequency_counter #(
        .ACLK_FREQUENCY(200000000), .NUM_CHANNELS(4), .CNT_WIDTH(8), .SYNC_STAGES(2)
    ) dut8 (
        .aclk(clk), .areset(areset), .sen_in(sen8), .irq(irq8), .ctrl(ifc8.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Periodic sensors: ch0 period 4, ch1 period 10, ch2 period 5; 8-bit build ch0 period 2
    initial begin
        cyc  = 0;
        sen  = '0;
        sen8 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            sen[0]    = (cyc % 4) < 2;
            sen[1]    = (cyc % 10) < 5;
            sen[2]    = (cyc % 5) < 2;
            sen[3]    = 1'b0;
            sen8[0]   = cyc[0];
            sen8[3:1] = 3'b000;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge clk);
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = a; m_wdata = d; m_wstrb = s; m_bready = 1'b1;
        #1;
        n = 0;
        while (!s_awready && n < 20) begin @(negedge clk); #1; n++; end
        if (!s_awready) begin
            checks++; failures++;
            $display("FAIL write_accept addr=%h got_awready=0 need=1", a);
        end
        @(posedge clk); #1;
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        if (!s_bvalid) begin
            checks++; failures++;
            $display("FAIL write_resp addr=%h got_bvalid=0 need=1", a);
        end
        resp = s_bresp;
        @(posedge clk); #1;
        m_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        m_arvalid = 1'b1; m_araddr = a; m_rready = 1'b0;
        #1;
        n = 0;
        while (!s_arready && n < 20) begin @(negedge clk); #1; n++; end
        if (!s_arready) begin
            checks++; failures++;
            $display("FAIL read_accept addr=%h got_arready=0 need=1", a);
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        if (!s_rvalid) begin
            checks++; failures++;
            $display("FAIL read_valid addr=%h got_rvalid=0 need=1", a);
        end
        d = s_rdata;
        r = s_rresp;
        m_rready = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0;
    endtask

    task automatic wait_irq(input int max, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_irq && n < max) begin @(negedge clk); n++; end
        at = tick;
        if (!s_irq) begin
            checks++; failures++;
            $display("FAIL irq_timeout got_irq=0 need=1 after %0d cycles", max);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        sel = 1'b0;
        do_reset();
        #1;
        checks++; if ({irq, irq8} !== 2'b00) begin failures++; $display("FAIL rst_irq got=%b need=00", {irq, irq8}); end
        checks++; if ({ifc.arready, ifc8.arready} !== 2'b11) begin failures++; $display("FAIL rst_arready got=%b need=11", {ifc.arready, ifc8.arready}); end
        checks++; if ({ifc.rvalid, ifc.bvalid, ifc.awready, ifc.wready} !== 4'b0000) begin failures++; $display("FAIL rst_outs got=%b need=0000", {ifc.rvalid, ifc.bvalid, ifc.awready, ifc.wready}); end
        axi_read(12'h008, d, r);
        checks++; if (d !== 32'd200000000) begin failures++; $display("FAIL rst_gate got=%0d need=200000000", d); end
        axi_read(12'h00C, d, r);
        checks++; if (d !== 32'h00002004) begin failures++; $display("FAIL rst_info got=%h need=00002004", d); end
        axi_read(12'h200, d, r);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin failures++; $display("FAIL unmapped_read got=%h/%b need=0/00", d, r); end
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_status got=%h need=0", d); end
        axi_read(12'h010, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_seq got=%h need=0", d); end
        axi_read(12'h110, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL result_oob got=%h need=0", d); end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        sel = 1'b0;
        axi_write(12'h008, 32'h000000FF, 4'b0001, r);
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL bresp got=%b need=00", r); end
        axi_read(12'h008, d, r);
        checks++; if (d !== 32'h0BEBC2FF) begin failures++; $display("FAIL wstrb_byte0 got=%h need=0bebc2ff", d); end
        axi_write(12'h008, 32'h0, 4'b1111, r);
        axi_read(12'h008, d, r);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL gate_zero got=%h need=1", d); end
        axi_write(12'h200, 32'hFFFFFFFF, 4'b1111, r);
        axi_read(12'h200, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_write got=%h need=0", d); end
        axi_read(12'h000, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_untouched got=%h need=0", d); end
    endtask

    task automatic test_single_shot();
        logic [31:0] d;
        logic [1:0]  r;
        int          at;
        sel = 1'b0;
        axi_write(12'h008, 32'd100, 4'b1111, r);
        axi_write(12'h000, 32'h7, 4'b1111, r);
        wait_irq(400, at);
        axi_read(12'h100, d, r);
        checks++; if (d !== 32'd25) begin failures++; $display("FAIL ss_result0 got=%0d need=25", d); end
        axi_read(12'h104, d, r);
        checks++; if (d !== 32'd10) begin failures++; $display("FAIL ss_result1 got=%0d need=10", d); end
        axi_read(12'h10C, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL ss_result3 got=%0d need=0", d); end
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL ss_status got=%h need=2", d); end
        axi_read(12'h010, d, r);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL ss_seq got=%0d need=1", d); end
        axi_read(12'h000, d, r);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL ss_ctrl got=%h need=3", d); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ss_irq got=%b need=1", irq); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [1:0]  r;
        sel = 1'b0;
        axi_write(12'h000, 32'h7, 4'b1111, r);
        repeat (40) @(posedge clk);
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL abort_busy got=%h need=3", d); end
        axi_write(12'h000, 32'h0, 4'b1111, r);
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL abort_idle got=%h need=2", d); end
        repeat (100) @(posedge clk);
        axi_read(12'h100, d, r);
        checks++; if (d !== 32'd25) begin failures++; $display("FAIL abort_result got=%0d need=25", d); end
        axi_read(12'h010, d, r);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL abort_seq got=%0d need=1", d); end
    endtask

    task automatic test_read_hold();
        int n;
        sel = 1'b0;
        @(negedge clk);
        m_arvalid = 1'b1; m_araddr = 12'h00C; m_rready = 1'b0;
        #1;
        n = 0;
        while (!s_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        m_araddr = 12'h008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h2004 || s_arready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d got=%b/%h/%b need=1/00002004/0", i, s_rvalid, s_rdata, s_arready);
            end
        end
        m_arvalid = 1'b0;
        m_rready  = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0;
        checks++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b/%b need=0/1", s_rvalid, s_arready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        sel = 1'b0;
        axi_write(12'h008, 32'd100, 4'b1111, r);
        axi_write(12'h000, 32'h7, 4'b1111, r);
        repeat (30) @(posedge clk);
        do_reset();
        axi_read(12'h100, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_rst_result got=%0d need=0", d); end
        axi_read(12'h010, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_rst_seq got=%0d need=0", d); end
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_rst_status got=%h need=0", d); end
        axi_read(12'h008, d, r);
        checks++; if (d !== 32'd200000000) begin failures++; $display("FAIL mid_rst_gate got=%0d need=200000000", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          at;
        int          prev;
        sel = 1'b0;
        prev = 0;
        axi_write(12'h008, 32'd50, 4'b1111, r);
        axi_write(12'h000, 32'h1, 4'b1111, r);
        for (int k = 1; k <= 10; k++) begin
            wait_irq(200, at);
            if (k > 1) begin
                checks++; if (at - prev !== 50) begin failures++; $display("FAIL window_len_%0d got=%0d need=50", k, at - prev); end
            end
            prev = at;
            axi_read(12'h108, d, r);
            checks++; if (d !== 32'd10) begin failures++; $display("FAIL cont_result2_%0d got=%0d need=10", k, d); end
            axi_read(12'h010, d, r);
            checks++; if (d !== 32'(k)) begin failures++; $display("FAIL cont_seq_%0d got=%0d need=%0d", k, d, k); end
            axi_write(12'h000, 32'h9, 4'b0001, r);
        end
        axi_write(12'h000, 32'h0, 4'b1111, r);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [1:0]  r;
        int          at;
        sel = 1'b1;
        axi_read(12'h00C, d, r);
        checks++; if (d !== 32'h00000804) begin failures++; $display("FAIL ovf_info got=%h need=00000804", d); end
        axi_write(12'h008, 32'd1000, 4'b1111, r);
        axi_write(12'h000, 32'h7, 4'b1111, r);
        wait_irq(1500, at);
        axi_read(12'h100, d, r);
        checks++; if (d !== 32'd255) begin failures++; $display("FAIL ovf_result got=%0d need=255", d); end
        axi_read(12'h014, d, r);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL ovf_bit got=%h need=1", d); end
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h00010002) begin failures++; $display("FAIL ovf_status got=%h need=00010002", d); end
        axi_write(12'h000, 32'h8, 4'b0001, r);
        axi_read(12'h014, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovf_cleared got=%h need=0", d); end
        axi_read(12'h004, d, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovf_status_clr got=%h need=0", d); end
        checks++; if (irq8 !== 1'b0) begin failures++; $display("FAIL ovf_irq_clr got=%b need=0", irq8); end
        axi_read(12'h100, d, r);
        checks++; if (d !== 32'd255) begin failures++; $display("FAIL ovf_result_kept got=%0d need=255", d); end
    endtask

    initial begin
        sel = 1'b0;
        areset = 1'b1;
        m_arvalid = 1'b0; m_rready = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        test_reset();
        test_wstrb();
        test_single_shot();
        test_abort();
        test_read_hold();
        test_reset_mid();
        test_back_to_back();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_frequency_counter.md
Name: multi_frequency_counter

Overview:
- Parametrised multi-channel frequency meter with an AXI4-Lite control slave.
- Samples NUM_CHANNELS asynchronous sensor signals in the aclk domain.
- Counts rising edges over a programmable gate window and latches the per-channel results for software.
- Adds single-shot and continuous modes, saturation/overflow flags and a window sequence counter; sits as a monitor peripheral on the control bus.

Parameters:
ACLK_FREQUENCY, 200000000, aclk rate in Hz; reset value of GATE_CYCLES (1 s window).
NUM_CHANNELS, 4, number of sensor inputs, 1..32.
CNT_WIDTH, 32, edge counter width, 8..32; results zero-extended to 32 bits.
SYNC_STAGES, 2, synchroniser flops per channel, 2..4.

Ports:
aclk  in  1  sole clock.
areset  in  1  synchronous active-high reset.
sen_in  in  NUM_CHANNELS  asynchronous sensor signals; each must be below aclk/2.
irq  out  1  level, equals STATUS.done.
ctrl_arvalid/ctrl_arready/ctrl_araddr[11:0]  AXI4-Lite read address.
ctrl_rvalid/ctrl_rready/ctrl_rdata[31:0]/ctrl_rresp[1:0]  read data.
ctrl_awvalid/ctrl_awready/ctrl_awaddr[11:0]  write address.
ctrl_wvalid/ctrl_wready/ctrl_wdata[31:0]/ctrl_wstrb[3:0]  write data.
ctrl_bvalid/ctrl_bready/ctrl_bresp[1:0]  write response.

Behaviour:
- Reset:
  - All outputs 0 except ctrl_arready=1.
  - CTRL=0, GATE_CYCLES=ACLK_FREQUENCY, SEQ=0, results=0, flags=0, FSM=IDLE.
- Register map (word offsets):
  - 0x000 CTRL rw: b0 enable, b1 mode (0 continuous, 1 single-shot).
  - 0x000 CTRL write-only pulses: b2 start (reads 0), b3 clear_flags (reads 0).
  - 0x004 STATUS ro: b0 busy (FSM=GATE), b1 done, b[31:16] overflow bits for ch0..15.
  - 0x008 GATE_CYCLES rw: a written 0 is stored as 1.
  - 0x00C INFO ro: [7:0] NUM_CHANNELS, [15:8] CNT_WIDTH.
  - 0x010 SEQ ro: completed windows, wraps at 2^32.
  - 0x014 OVF ro: overflow bits for all channels.
  - 0x100+4*i RESULT[i] ro.
  - Unmapped or i>=NUM_CHANNELS: read 0; writes ignored. All resp OKAY (2'b00).
- Read channel:
  - ctrl_arready=!ctrl_rvalid.
  - AR accepted on arvalid&&arready; rvalid asserts the next cycle with rdata.
  - rdata/rvalid held stable until rready.
- Write channel:
  - ctrl_awready=ctrl_wready=awvalid&&wvalid&&!bvalid; both accepted in the same cycle.
  - wstrb byte enables honoured on rw registers; start/clear act only if byte 0 is strobed.
  - bvalid asserts the next cycle and holds until bready.
- Per channel: SYNC_STAGES-flop synchroniser, then rising-edge detect.
  - Edge pulse latency = SYNC_STAGES+1 cycles after the input transition.
- FSM IDLE -> GATE:
  - Taken when enable && (mode==0 || start pulse).
  - Loads timer=GATE_CYCLES-1 and zeroes the running counters.
- In GATE:
  - Counters increment on edge pulses and saturate at 2^CNT_WIDTH-1.
  - An edge arriving while saturated sets the sticky overflow bit.
- Terminal cycle (timer==0):
  - RESULT[i] <= running count including the current edge; done<=1; SEQ++.
  - Counters reload to 0 and timer reloads from the current GATE_CYCLES.
  - Continuous mode stays in GATE: windows are back-to-back with exactly GATE_CYCLES cycles each and no edge lost.
  - Single-shot mode goes to IDLE.
- enable cleared mid-GATE: abort to IDLE next cycle; RESULT, SEQ and done unchanged.
- GATE_CYCLES written mid-window: takes effect at the next reload.
- start while busy: ignored.
- clear_flags clears done and overflow; if it coincides with a terminal cycle, the terminal set wins.
- Sensor edges while IDLE are not counted.
- areset mid-window: full reset, no partial latch.

Decomposition:
- Package multi_frequency_counter_pkg: register offsets, CTRL/STATUS bit indices, RESULT_BASE=0x100, FSM enum {IDLE, GATE}, resp constant OKAY.
- Sub-module freq_counter_channel: synchroniser, edge detect, saturating counter and overflow flag for one channel, instantiated NUM_CHANNELS times in a generate loop.
- Top level: AXI-Lite slave, FSM/timer, result registers.

Test Plan:
- Reset, then read 0x008 and 0x00C -> 200000000 and 0x00002004; any read of 0x200 -> 0, rresp 0.
- GATE_CYCLES=100, mode=1, start; ch0 has a rising edge every 4 cycles, ch1 every 10 cycles -> RESULT[0]=25, RESULT[1]=10, done=1, irq=1, SEQ=1, busy=0.
- Continuous mode, GATE_CYCLES=50, ch2 edge every 5 cycles for 10 windows -> every latched RESULT[2]=10, SEQ=10, no drift across window boundaries.
- CNT_WIDTH=8, GATE_CYCLES=1000, ch0 edge every 2 cycles -> RESULT[0]=255, OVF bit0=1; write clear_flags -> OVF=0, done=0.
- Clear enable at cycle 40 of a 100-cycle window -> busy drops next cycle; RESULT and SEQ keep their previous values.
- Hold rready low for 5 cycles -> rvalid and rdata stable and arready=0 throughout.
- Write GATE_CYCLES with wstrb=4'b0001 and wdata=0xFF -> only byte 0 changes.
